// File: rtl/counter_monitor.sv
// Watches a saturating up/down counter and flags the first protocol violation.
// Steps are checked one edge after cnt is presented; all outputs are registered.
module counter_monitor (
    input  logic              clk,
    input  logic              rst,
    input  logic signed [9:0] cnt,
    input  logic              limit,
    output logic              dir_up,
    output logic              dir_valid,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [7:0]        sat_cnt,
    output logic [15:0]       step_cnt,
    output logic [1:0]        o_state
);

    typedef enum logic [1:0] {
        S_SYNC  = 2'd0,
        S_TRACK = 2'd1,
        S_FAIL  = 2'd2
    } state_t;

    state_t             r_state;
    logic signed [9:0]  r_prev;
    logic               r_dir_up;
    logic               r_dir_valid;
    logic               r_err;
    logic [1:0]         r_err_code;
    logic [7:0]         r_sat_cnt;
    logic [15:0]        r_step_cnt;

    logic signed [10:0] w_delta;
    logic signed [10:0] w_up_step;
    logic signed [10:0] w_dn_step;
    logic               w_up_ok;
    logic               w_dn_ok;
    logic               w_legal;
    logic               w_limit_ok;

    // 11-bit difference covers the full -1023..1023 span of two 10-bit values.
    assign w_delta = {cnt[9], cnt} - {r_prev[9], r_prev};

    always_comb begin
        w_up_step = 11'sd0;
        w_dn_step = 11'sd0;
        if (r_prev == -10'sd16)
            w_up_step = 11'sd10;
        else if (r_prev <= 10'sd230)
            w_up_step = 11'sd5;
        if (r_prev == -10'sd2)
            w_dn_step = -11'sd18;
        else if (r_prev >= -10'sd221)
            w_dn_step = -11'sd9;
    end

    // Up and down rules can only both give 0 for disjoint prev ranges, so no overlap.
    assign w_up_ok    = (w_delta == w_up_step);
    assign w_dn_ok    = (w_delta == w_dn_step);
    assign w_legal    = w_up_ok | w_dn_ok;
    assign w_limit_ok = (limit == (w_delta == 11'sd0));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_SYNC;
            r_prev      <= -10'sd50;
            r_dir_up    <= 1'b0;
            r_dir_valid <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= 2'd0;
            r_sat_cnt   <= 8'd0;
            r_step_cnt  <= 16'd0;
        end else begin
            case (r_state)
                S_SYNC: begin
                    if (cnt == -10'sd50) begin
                        r_prev  <= cnt;
                        r_state <= S_TRACK;
                    end else begin
                        r_err      <= 1'b1;
                        r_err_code <= 2'd1;
                        r_state    <= S_FAIL;
                    end
                end
                S_TRACK: begin
                    r_prev <= cnt;
                    if (!w_legal) begin
                        r_err      <= 1'b1;
                        r_err_code <= 2'd2;
                        r_state    <= S_FAIL;
                    end else if (!w_limit_ok) begin
                        r_err      <= 1'b1;
                        r_err_code <= 2'd3;
                        r_state    <= S_FAIL;
                    end else begin
                        r_dir_up    <= w_up_ok;
                        r_dir_valid <= 1'b1;
                        if (w_delta != 11'sd0)
                            r_step_cnt <= r_step_cnt + 16'd1;
                        if (limit && (r_sat_cnt != 8'hFF))
                            r_sat_cnt <= r_sat_cnt + 8'd1;
                    end
                end
                default: begin
                    // FAIL keeps every output frozen until reset.
                end
            endcase
        end
    end

    assign dir_up    = r_dir_up;
    assign dir_valid = r_dir_valid;
    assign err       = r_err;
    assign err_code  = r_err_code;
    assign sat_cnt   = r_sat_cnt;
    assign step_cnt  = r_step_cnt;
    assign o_state   = r_state;

endmodule

// File: tb/tb_counter_monitor.sv
// Directed bench for counter_monitor: driver pushes expected snapshots tagged by
// clock edge; a negedge monitor pops and compares them against the DUT outputs.
module tb_counter_monitor;

    localparam logic [1:0] ST_SYNC  = 2'd0;
    localparam logic [1:0] ST_TRACK = 2'd1;
    localparam logic [1:0] ST_FAIL  = 2'd2;

    logic              clk = 1'b0;
    logic              rst;
    logic signed [9:0] cnt;
    logic              limit;
    logic              dir_up;
    logic              dir_valid;
    logic              err;
    logic [1:0]        err_code;
    logic [7:0]        sat_cnt;
    logic [15:0]       step_cnt;
    logic [1:0]        o_state;

    int                edge_cnt = 0;
    int                n_tests  = 0;
    int                n_fail   = 0;
    logic signed [9:0] cur;

    logic [30:0]       exp_q[$];
    int                tag_q[$];
    string             name_q[$];

    counter_monitor dut (
        .clk       (clk),
        .rst       (rst),
        .cnt       (cnt),
        .limit     (limit),
        .dir_up    (dir_up),
        .dir_valid (dir_valid),
        .err       (err),
        .err_code  (err_code),
        .sat_cnt   (sat_cnt),
        .step_cnt  (step_cnt),
        .o_state   (o_state)
    );

    // clock / edge counter
    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic logic [30:0] mk(input logic [1:0] st, input logic du, input logic dv,
                                       input logic er, input logic [1:0] ec,
                                       input logic [7:0] sc, input logic [15:0] stc);
        return {st, du, dv, er, ec, sc, stc};
    endfunction

    // driver tasks: inputs change 1 time unit after a rising edge
    task automatic drive(input logic r, input logic signed [9:0] c, input logic l);
        rst   = r;
        cnt   = c;
        limit = l;
        cur   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, cur, 1'b0);
    endtask

    task automatic up(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, cur + 10'sd5, 1'b0);
    endtask

    task automatic down(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, cur - 10'sd9, 1'b0);
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, cur, 1'b1);
    endtask

    // expectation for the edge that just consumed the last driven vector
    task automatic expect_now(input string nm, input logic [30:0] e);
        exp_q.push_back(e);
        tag_q.push_back(edge_cnt);
        name_q.push_back(nm);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [30:0] act;
        logic [30:0] e;
        string       nm;
        act = {o_state, dir_up, dir_valid, err, err_code, sat_cnt, step_cnt};
        if (tag_q.size() > 0 && tag_q[0] <= edge_cnt) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_tests++;
            if (tag_q.pop_front() != edge_cnt) begin
                n_fail++;
                $display("FAIL %s: expectation missed its edge (now %0d)", nm, edge_cnt);
            end else if (act !== e) begin
                n_fail++;
                $display("FAIL %s: got st=%0d up=%0b v=%0b err=%0b code=%0d sat=%0d step=%0d, want st=%0d up=%0b v=%0b err=%0b code=%0d sat=%0d step=%0d",
                         nm, act[30:29], act[28], act[27], act[26], act[25:24], act[23:16], act[15:0],
                         e[30:29], e[28], e[27], e[26], e[25:24], e[23:16], e[15:0]);
            end
        end
    end

    initial begin
        rst   = 1'b1;
        cnt   = '0;
        limit = 1'b0;
        cur   = '0;
        @(posedge clk);
        #1;

        // reset state
        do_reset();
        expect_now("reset", mk(ST_SYNC, 0, 0, 0, 2'd0, 8'd0, 16'd0));

        // simple up run
        drive(1'b0, -10'sd50, 1'b0);
        expect_now("sync_ok", mk(ST_TRACK, 0, 0, 0, 2'd0, 8'd0, 16'd0));
        up(2);
        expect_now("up_seq", mk(ST_TRACK, 1, 1, 0, 2'd0, 8'd0, 16'd2));

        // down run to -230 (passes -221 boundary) then held at lower limit
        do_reset();
        drive(1'b0, -10'sd50, 1'b0);
        down(20);
        expect_now("down_seq", mk(ST_TRACK, 0, 1, 0, 2'd0, 8'd0, 16'd20));
        hold(3);
        expect_now("down_hold", mk(ST_TRACK, 0, 1, 0, 2'd0, 8'd3, 16'd20));

        // special steps: -21 -> -16 -> -6 and -7 -> -2 -> -20
        do_reset();
        drive(1'b0, -10'sd50, 1'b0);
        up(13);
        down(4);
        drive(1'b0, -10'sd16, 1'b0);
        drive(1'b0, -10'sd6, 1'b0);
        expect_now("special_up", mk(ST_TRACK, 1, 1, 0, 2'd0, 8'd0, 16'd19));
        down(4);
        up(7);
        drive(1'b0, -10'sd2, 1'b0);
        drive(1'b0, -10'sd20, 1'b0);
        expect_now("special_dn", mk(ST_TRACK, 0, 1, 0, 2'd0, 8'd0, 16'd32));

        // bad first value, then FAIL stays frozen
        do_reset();
        drive(1'b0, -10'sd40, 1'b0);
        expect_now("bad_sync", mk(ST_FAIL, 0, 0, 1, 2'd1, 8'd0, 16'd0));
        drive(1'b0, -10'sd45, 1'b0);
        drive(1'b0, -10'sd40, 1'b0);
        expect_now("fail_frozen", mk(ST_FAIL, 0, 0, 1, 2'd1, 8'd0, 16'd0));

        // TRACK error codes
        do_reset();
        drive(1'b0, -10'sd50, 1'b0);
        drive(1'b0, -10'sd47, 1'b0);
        expect_now("bad_step", mk(ST_FAIL, 0, 0, 1, 2'd2, 8'd0, 16'd0));
        do_reset();
        drive(1'b0, -10'sd50, 1'b0);
        drive(1'b0, -10'sd45, 1'b1);
        expect_now("limit_mis", mk(ST_FAIL, 0, 0, 1, 2'd3, 8'd0, 16'd0));
        do_reset();
        drive(1'b0, -10'sd50, 1'b0);
        drive(1'b0, -10'sd50, 1'b0);
        expect_now("zero_step", mk(ST_FAIL, 0, 0, 1, 2'd2, 8'd0, 16'd0));
        do_reset();
        expect_now("rst_from_fail", mk(ST_SYNC, 0, 0, 0, 2'd0, 8'd0, 16'd0));

        // mid-run reset
        drive(1'b0, -10'sd50, 1'b0);
        up(1);
        expect_now("pre_rst", mk(ST_TRACK, 1, 1, 0, 2'd0, 8'd0, 16'd1));
        do_reset();
        expect_now("mid_rst", mk(ST_SYNC, 0, 0, 0, 2'd0, 8'd0, 16'd0));

        // upper boundary and sat_cnt saturation
        drive(1'b0, -10'sd50, 1'b0);
        up(56);
        expect_now("at_230", mk(ST_TRACK, 1, 1, 0, 2'd0, 8'd0, 16'd56));
        up(1);
        hold(255);
        expect_now("sat_255", mk(ST_TRACK, 1, 1, 0, 2'd0, 8'd255, 16'd57));
        hold(5);
        expect_now("sat_hold", mk(ST_TRACK, 1, 1, 0, 2'd0, 8'd255, 16'd57));
        drive(1'b0, cur, 1'b0);
        expect_now("hold_nolimit", mk(ST_FAIL, 1, 1, 1, 2'd3, 8'd255, 16'd57));
        do_reset();
        drive(1'b0, -10'sd50, 1'b0);
        up(57);
        drive(1'b0, 10'sd240, 1'b0);
        expect_now("up_past_top", mk(ST_FAIL, 1, 1, 1, 2'd2, 8'd0, 16'd57));

        // step_cnt wrap: 4681 loops of 14 steps plus one = 65535
        do_reset();
        drive(1'b0, -10'sd50, 1'b0);
        for (int k = 0; k < 4681; k++) begin
            up(9);
            down(5);
        end
        up(1);
        expect_now("step_65535", mk(ST_TRACK, 1, 1, 0, 2'd0, 8'd0, 16'hFFFF));
        up(1);
        expect_now("step_wrap", mk(ST_TRACK, 1, 1, 0, 2'd0, 8'd0, 16'd0));

        // drain the scoreboard, bounded
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (tag_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", tag_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
